// File: rtl/riscv_if_id_queue_if.sv
// IF/ID queue handshake bundle: enqueue side from IF, dequeue side to ID,
// plus flush and occupancy status. master = IF/ID pipeline control, slave = queue.
interface riscv_if_id_queue_if #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            flush;
  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc;
  logic [ILEN-1:0] enq_instr;
  logic            deq_ready;
  logic            deq_valid;
  logic [XLEN-1:0] deq_pc;
  logic [ILEN-1:0] deq_instr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;

  modport master (
    output flush, enq_valid, enq_pc, enq_instr, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_instr, count, full, empty
  );

  modport slave (
    input  flush, enq_valid, enq_pc, enq_instr, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_instr, count, full, empty
  );
endinterface

// File: rtl/riscv_if_id_queue.sv
// DEPTH-entry (PC, instruction) prefetch queue between IF and ID; NOP presented when empty.
// Optional macro IF_ID_QUEUE_BYPASS_EN: empty-queue fall-through giving 0-cycle latency.
module riscv_if_id_queue #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013)
) (
  input logic                clk,
  input logic                reset,
  riscv_if_id_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [ILEN-1:0] instr_mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;

  logic            empty_s;
  logic            full_s;
  logic            bypass_s;
  logic            deq_valid_s;
  logic            enq_fire_s;
  logic            deq_fire_s;
  logic            wr_en_s;
  logic            rd_en_s;
  logic [XLEN-1:0] deq_pc_s;
  logic [ILEN-1:0] deq_instr_s;

  assign empty_s = (count_r == CW'(0));
  assign full_s  = (count_r == CW'(DEPTH));

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypass_s = empty_s & q.enq_valid & ~q.flush;
`else
  assign bypass_s = 1'b0;
`endif

  assign deq_valid_s = ~empty_s | bypass_s;
  assign enq_fire_s  = q.enq_valid & ~full_s;
  assign deq_fire_s  = deq_valid_s & q.deq_ready;

  // A bypassed entry consumed in the same cycle never touches storage or pointers
  assign wr_en_s = enq_fire_s & ~(bypass_s & q.deq_ready);
  assign rd_en_s = deq_fire_s & ~bypass_s;

  // Pointer and occupancy state; flush outranks any concurrent enqueue/dequeue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (q.flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are unobservable while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_en_s && !q.flush) begin
      pc_mem_r[wr_ptr_r]    <= q.enq_pc;
      instr_mem_r[wr_ptr_r] <= q.enq_instr;
    end
  end

  // Head read: stored entry, bypassed fetch, or NOP when nothing is available
  always_comb begin
    deq_pc_s    = '0;
    deq_instr_s = NOP_INSTR;
    if (!empty_s) begin
      deq_pc_s    = pc_mem_r[rd_ptr_r];
      deq_instr_s = instr_mem_r[rd_ptr_r];
    end else if (bypass_s) begin
      deq_pc_s    = q.enq_pc;
      deq_instr_s = q.enq_instr;
    end else begin
      deq_pc_s    = '0;
      deq_instr_s = NOP_INSTR;
    end
  end

  assign q.enq_ready = ~full_s;
  assign q.deq_valid = deq_valid_s;
  assign q.deq_pc    = deq_pc_s;
  assign q.deq_instr = deq_instr_s;
  assign q.count     = count_r;
  assign q.full      = full_s;
  assign q.empty     = empty_s;
endmodule

// File: tb/tb_riscv_if_id_queue.sv
// Scoreboard bench for riscv_if_id_queue; honours IF_ID_QUEUE_BYPASS_EN when defined.
module tb_riscv_if_id_queue;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ID_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  ent_t sb_q[$];
  bit   last_acc;
  logic [31:0] next_pc;

  riscv_if_id_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

  riscv_if_id_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ pc;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Compare all outputs against the model mid-cycle, then advance the model at the edge
  task automatic step();
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    int          sz;
    @(negedge clk);
    sz = sb_q.size();
    exp_valid = 1'b0;
    exp_pc    = 32'h0;
    exp_instr = NOP;
    if (sz > 0) begin
      exp_valid = 1'b1;
      exp_pc    = sb_q[0].pc;
      exp_instr = sb_q[0].instr;
    end else if (BYP && bus.enq_valid && !bus.flush) begin
      exp_valid = 1'b1;
      exp_pc    = bus.enq_pc;
      exp_instr = bus.enq_instr;
    end
    check_val("deq_valid", 64'(bus.deq_valid), 64'(exp_valid));
    check_val("deq_pc",    64'(bus.deq_pc),    64'(exp_pc));
    check_val("deq_instr", 64'(bus.deq_instr), 64'(exp_instr));
    check_val("count",     64'(bus.count),     64'(sz));
    check_val("full",      64'(bus.full),      64'(sz == DEPTH));
    check_val("empty",     64'(bus.empty),     64'(sz == 0));
    check_val("enq_ready", 64'(bus.enq_ready), 64'(sz != DEPTH));
    @(posedge clk);
    last_acc = 1'b0;
    if (bus.flush) begin
      sb_q.delete();
    end else if (BYP && sz == 0 && bus.enq_valid && bus.deq_ready) begin
      last_acc = 1'b1;
    end else begin
      if (sz > 0 && bus.deq_ready) begin
        void'(sb_q.pop_front());
      end
      if (bus.enq_valid && sz < DEPTH) begin
        sb_q.push_back('{pc: bus.enq_pc, instr: bus.enq_instr});
        last_acc = 1'b1;
      end
    end
    #1;
  endtask

  task automatic drive(input logic ev, input logic [31:0] pc, input logic dr, input logic fl);
    bus.enq_valid = ev;
    bus.enq_pc    = pc;
    bus.enq_instr = instr_of(pc);
    bus.deq_ready = dr;
    bus.flush     = fl;
  endtask

  task automatic drain();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 2 && sb_q.size() > 0; i++) begin
      step();
    end
    check_val("drain_empty", 64'(bus.empty), 64'(1));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #12;
    check_val("rst_count", 64'(bus.count),     64'(0));
    check_val("rst_instr", 64'(bus.deq_instr), 64'(NOP));
    reset = 1'b0;
    @(posedge clk);
    #1;
    step();

    // Fill to full, then try a fifth entry
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    step();
    check_val("fifth_rejected", 64'(last_acc), 64'(0));
    check_val("fill_head", 64'(bus.deq_pc), 64'(32'h0));

    // Drain while streaming; the fetch PC only advances once accepted
    next_pc = 32'h10;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, next_pc, 1'b1, 1'b0);
      step();
      if (last_acc) next_pc = next_pc + 32'h4;
    end
    drain();

    // Stall: two entries, deq_ready 1,0,1
    drive(1'b1, 32'h20, 1'b0, 1'b0); step();
    drive(1'b1, 32'h24, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);  step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);  step();
    check_val("stall_hold", 64'(bus.deq_pc), 64'(32'h24));
    drive(1'b0, 32'h0, 1'b1, 1'b0);  step();
    drain();

    // Flush with concurrent enqueue/dequeue, then refill
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h30 + i * 4), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h40, 1'b1, 1'b1);
    step();
    check_val("flush_count", 64'(bus.count), 64'(0));
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_val("after_flush_pc", 64'(bus.deq_pc), 64'(32'h80));
    drain();

    // Empty queue with enq_valid and deq_ready together
    drive(1'b1, 32'h100, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_val("bypass_count", 64'(bus.count), 64'(BYP ? 0 : 1));
    drain();

    // Random traffic with occasional flushes
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      step();
    end

    // Asynchronous reset between edges with three entries queued
    drain();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h200 + i * 4), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_count", 64'(bus.count),     64'(0));
    check_val("arst_empty", 64'(bus.empty),     64'(1));
    check_val("arst_instr", 64'(bus.deq_instr), 64'(NOP));
    check_val("arst_pc",    64'(bus.deq_pc),    64'(0));
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
